// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   DATA_WIDTH_DEF   : default width of PC and instruction words
//   RESET_VECTOR_DEF : default first fetch address after reset
//   QUEUE_DEPTH_DEF  : default number of instruction queue entries
//   fetch_entry_t    : one queued fetch, {pc, instr}
package fetch_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;
  localparam int unsigned QUEUE_DEPTH_DEF  = 4;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] pc;
    logic [DATA_WIDTH_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   flush              : empties the queue; wins over push and pop
//   push, push_data    : append one entry (caller guarantees room, or a
//                        simultaneous pop when full)
//   pop                : drop the head entry (caller guarantees non-empty)
//   head               : entry at the head, valid while !empty
//   count, full, empty : occupancy
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = QUEUE_DEPTH_DEF,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic [AW:0] count,
  output logic   full,
  output logic   empty
);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Storage has no reset; only the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Push and pop together (including when full) leave count unchanged.
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: fetch PC register, instruction memory
// address, and an in-order queue feeding decode over valid/ready.
// Handshake: an instruction transfers to decode in a cycle where
// instr_valid_o and instr_ready_i are both high; instr_o/pc_o/pc_plus4_o
// are held stable while instr_valid_o is high and instr_ready_i is low.
// Ports:
//   clk_i, rst_ni         : clock, synchronous active-low reset
//   imem_addr_o           : fetch address (the fetch PC)
//   imem_instr_i          : combinational memory read data for imem_addr_o
//   redirect_i            : control-flow redirect; flushes queue
//   redirect_pc_i         : redirect target, bits [1:0] ignored
//   instr_valid_o         : head instruction valid
//   instr_ready_i         : decode accepts head
//   instr_o, pc_o         : head instruction and its PC
//   pc_plus4_o            : pc_o + 4
// Build option: FETCH_BYPASS_EN presents the memory word directly to
// decode when the queue is empty (zero-cycle fetch latency).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0]   RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned             QUEUE_DEPTH  = QUEUE_DEPTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);

  logic [DATA_WIDTH-1:0] pc_q;
  entry_t                head;
  entry_t                push_data;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  q_push;
  logic                  q_pop;
  logic                  advance;
  logic                  unused;

  assign unused      = ^{redirect_pc_i[1:0], count};
  assign imem_addr_o = pc_q;
  assign push_data   = '{pc: pc_q, instr: imem_instr_i};

  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = head.instr;
    pc_o          = head.pc;
    q_pop         = 1'b0;
    advance       = 1'b0;
    q_push        = 1'b0;
`ifdef FETCH_BYPASS_EN
    // Empty queue: the memory word itself is the head.
    instr_valid_o = !redirect_i;
    if (empty) begin
      instr_o = imem_instr_i;
      pc_o    = pc_q;
    end
    q_pop   = !empty && !redirect_i && instr_ready_i;
    advance = !redirect_i && (!full || q_pop);
    // A bypassed word taken by decode is never written into the queue.
    q_push  = advance && !(empty && instr_ready_i);
`else
    instr_valid_o = !empty && !redirect_i;
    q_pop         = instr_valid_o && instr_ready_i;
    advance       = !redirect_i && (!full || q_pop);
    q_push        = advance;
`endif
  end

  assign pc_plus4_o = pc_o + DATA_WIDTH'(4);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= {RESET_VECTOR[DATA_WIDTH-1:2], 2'b00};
    end else if (redirect_i) begin
      pc_q <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    end else if (advance) begin
      pc_q <= pc_q + DATA_WIDTH'(4);
    end
  end

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (redirect_i),
    .push      (q_push),
    .push_data (push_data),
    .pop       (q_pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RV   = 32'hBFC00000;
  localparam logic [31:0] PATT = 32'hA5A5A5A5;
  localparam int          QD   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: each word is its address XOR a pattern.
  assign imem_instr = imem_addr ^ PATT;

  fetch_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of {pc, instr} that decode should see, plus the fetch address.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;

  function automatic logic m_valid();
`ifdef FETCH_BYPASS_EN
    return !redirect;
`else
    return !redirect && (exp_q.size() > 0);
`endif
  endfunction

  function automatic logic [63:0] m_head();
    if (exp_q.size() > 0) return exp_q[0];
    return {m_pc, m_pc ^ PATT};
  endfunction

  task automatic model_check();
    logic [63:0] h;
    if (!rst_n) return;
    h = m_head();
    check("addr", imem_addr, m_pc);
    check("valid", {31'b0, instr_valid}, {31'b0, m_valid()});
    if (m_valid()) begin
      check("pc", pc, h[63:32]);
      check("instr", instr, h[31:0]);
      check("pc_plus4", pc_plus4, h[63:32] + 32'd4);
    end
  endtask

  task automatic model_update();
    logic pop;
    logic was_empty;
    logic room;
    if (!rst_n) begin
      exp_q.delete();
      m_pc = RV;
    end else if (redirect) begin
      exp_q.delete();
      m_pc = redirect_pc & ~32'd3;
    end else begin
      pop       = m_valid() && instr_ready;
      was_empty = (exp_q.size() == 0);
      room      = (exp_q.size() < QD) || pop;
      if (pop && !was_empty) void'(exp_q.pop_front());
      if (room) begin
`ifdef FETCH_BYPASS_EN
        if (!(was_empty && instr_ready)) exp_q.push_back({m_pc, m_pc ^ PATT});
`else
        exp_q.push_back({m_pc, m_pc ^ PATT});
`endif
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    rst_n       = r;
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
  endtask

  // Inputs change 1 ns after the rising edge; outputs sampled mid-cycle.
  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_n;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        chk;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy,
                     input logic chk, input logic ev, input logic [31:0] ea, input logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.redirect = rd; v.rpc = rpc; v.ready = rdy;
    v.chk = chk; v.exp_valid = ev; v.exp_addr = ea; v.exp_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    // Streaming with ready high.
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, RV,        0);
    add(1, 0, 0, 1, 1, 1, RV + 4,    RV);
    add(1, 0, 0, 1, 1, 1, RV + 8,    RV + 4);
    add(1, 0, 0, 1, 1, 1, RV + 12,   RV + 8);
    // Ready low for 10 cycles: queue fills, address parks at +0x10.
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, RV,        0);
    add(1, 0, 0, 0, 1, 1, RV + 4,    RV);
    add(1, 0, 0, 0, 1, 1, RV + 8,    RV);
    add(1, 0, 0, 0, 1, 1, RV + 12,   RV);
    for (int i = 4; i < 10; i++) add(1, 0, 0, 0, 1, 1, RV + 16, RV);
    // Release: drain with no gap.
    for (int i = 0; i < 5; i++) add(1, 0, 0, 1, 1, 1, RV + 16 + 4*i, RV + 4*i);
    // Full, then redirect to an unaligned target.
    add(1, 0, 0, 0, 1, 1, RV + 36, RV + 20);
    add(1, 1, 32'hBFC00123, 1, 1, 0, RV + 36, 0);
    add(1, 0, 0, 1, 1, 0, 32'hBFC00120, 0);
    add(1, 0, 0, 1, 1, 1, 32'hBFC00124, 32'hBFC00120);
    // Redirect near the top of the address space: PC wraps.
    add(1, 1, 32'hFFFFFFF8, 1, 1, 0, 32'hBFC00128, 0);
    add(1, 0, 0, 1, 1, 0, 32'hFFFFFFF8, 0);
    add(1, 0, 0, 1, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFF8);
    add(1, 0, 0, 1, 1, 1, 32'h00000000, 32'hFFFFFFFC);
    add(1, 0, 0, 1, 1, 1, 32'h00000004, 32'h00000000);
    // Build three entries, then reset together with redirect.
    add(1, 0, 0, 0, 1, 1, 32'h00000008, 32'h00000004);
    add(1, 0, 0, 0, 1, 1, 32'h0000000C, 32'h00000004);
    add(0, 1, 32'h12345678, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, RV, 0);
    add(1, 0, 0, 0, 1, 1, RV + 4, RV);
  endtask

  // ---------------- test ----------------
  initial begin
    drive(0, 0, 0, 0);
    exp_q.delete();
    m_pc = RV;
    @(posedge clk);
    #1;

    build_table();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].redirect, vecs[i].rpc, vecs[i].ready);
      #4;
      model_check();
`ifndef FETCH_BYPASS_EN
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
        check($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
        if (vecs[i].exp_valid) check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      end
`endif
      advance();
    end

    // Hand sequence: pc_plus4 wraps at the top of the address space.
    drive(1, 1, 32'hFFFFFFFC, 1);
    #4; model_check(); advance();
    drive(1, 0, 0, 0);
    #4; model_check(); advance();
    #4;
    model_check();
    check("wrap_pc_plus4", pc_plus4, 32'h00000000);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, tgt,
            $urandom_range(0, 9) < 7);
      #4;
      model_check();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
